// File: rtl/eclair_dma_pkg.sv
// Shared definitions for the ECLair DMA engine: FSM encodings, config selects
// and a width helper for channel indices.
package eclair_dma_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_REQ     = 3'd1;
    localparam state_t ST_LOAD    = 3'd2;
    localparam state_t ST_SETUP   = 3'd3;
    localparam state_t ST_STROBE  = 3'd4;
    localparam state_t ST_RELEASE = 3'd5;

    localparam logic CFG_SEL_ADDR  = 1'b0;
    localparam logic CFG_SEL_COUNT = 1'b1;

    // Channel index width, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/eclair_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module eclair_rr_arbiter
    import eclair_dma_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   idx,
    output logic              valid
);

    int unsigned j;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int unsigned off = 0; off < NUM_CH; off++) begin
            j = 32'(ptr) + off;
            if (j >= NUM_CH) j = j - NUM_CH;
            if (!valid && req[CH_W'(j)]) begin
                valid             = 1'b1;
                grant[CH_W'(j)]   = 1'b1;
                idx               = CH_W'(j);
            end
        end
    end

endmodule

// File: rtl/eclair_dma_engine.sv
// Multi-channel DMA engine: round-robin arbitration, CPU bus handshake and
// setup/strobe byte writes with per-channel address/count and sticky done.
module eclair_dma_engine
    import eclair_dma_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned ADDR_W    = 24,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BURST_LEN = 4,
    localparam int unsigned CH_W     = idx_width(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_ack,
    output logic                     dma_req,
    input  logic                     dma_ack,
    output logic [ADDR_W-1:0]        bus_addr,
    output logic [DATA_W-1:0]        bus_data,
    output logic                     bus_write,
    input  logic                     cfg_we,
    input  logic [CH_W-1:0]          cfg_ch,
    input  logic                     cfg_sel,
    input  logic [ADDR_W-1:0]        cfg_wdata,
    output logic [NUM_CH-1:0]        ch_done,
    output logic                     irq
);

    localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);

    state_t              state, state_next;
    logic                ack_meta, ack_s;
    logic [CH_W-1:0]     act, act_inc, rr_ptr, arb_idx;
    logic [BEAT_W-1:0]   beats, beats_inc;
    logic [ADDR_W-1:0]   addr_r  [NUM_CH];
    logic [ADDR_W-1:0]   count_r [NUM_CH];
    logic [ADDR_W-1:0]   count_dec;
    logic [NUM_CH-1:0]   eligible, arb_grant, done_next;
    logic                arb_valid, last_beat, cfg_ok, in_tenure;

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            eligible[i] = ch_req[i] && (count_r[i] != '0);
        end
    end

    eclair_rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
        .req   (eligible),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    assign count_dec = count_r[act] - ADDR_W'(1);
    assign beats_inc = beats + BEAT_W'(1);
    assign act_inc   = (32'(act) == NUM_CH - 1) ? '0 : act + CH_W'(1);
    assign last_beat = (count_dec == '0) || (beats_inc == BEAT_W'(BURST_LEN)) || !ack_s;
    // Writes aimed at the channel currently holding the bus are dropped.
    assign cfg_ok    = cfg_we && (32'(cfg_ch) < NUM_CH) && !((state != ST_IDLE) && (cfg_ch == act));
    assign in_tenure = state_next inside {ST_REQ, ST_LOAD, ST_SETUP, ST_STROBE};

    // dma_ack is asynchronous to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= dma_ack;
            ack_s    <= ack_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (arb_valid) state_next = ST_REQ;
            ST_REQ:     if (ack_s) state_next = ST_LOAD;
            ST_LOAD:    state_next = (!ack_s || !ch_req[act]) ? ST_RELEASE : ST_SETUP;
            ST_SETUP:   state_next = !ack_s ? ST_RELEASE : ST_STROBE;
            ST_STROBE:  state_next = last_beat ? ST_RELEASE : ST_LOAD;
            ST_RELEASE: if (!ack_s) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        done_next = ch_done;
        if (state == ST_STROBE && count_dec == '0) done_next[act] = 1'b1;
        if (cfg_ok && cfg_sel == CFG_SEL_COUNT) done_next[cfg_ch] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act       <= '0;
            rr_ptr    <= '0;
            beats     <= '0;
            bus_addr  <= '0;
            bus_data  <= '0;
            bus_write <= 1'b0;
            ch_ack    <= '0;
            dma_req   <= 1'b0;
            ch_done   <= '0;
            irq       <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                addr_r[i]  <= '0;
                count_r[i] <= '0;
            end
        end else begin
            dma_req   <= in_tenure;
            bus_write <= (state_next == ST_STROBE);
            ch_ack    <= (state_next == ST_STROBE) ? (NUM_CH'(1) << act) : '0;
            ch_done   <= done_next;
            irq       <= |done_next;
            if (state == ST_IDLE && arb_valid) begin
                act   <= arb_idx;
                beats <= '0;
            end
            if (state == ST_LOAD && state_next == ST_SETUP) begin
                bus_addr <= addr_r[act];
                bus_data <= ch_data[32'(act)*DATA_W +: DATA_W];
            end
            if (state == ST_STROBE) begin
                addr_r[act]  <= addr_r[act] + ADDR_W'(1);
                count_r[act] <= count_dec;
                beats        <= beats_inc;
            end
            if (state == ST_RELEASE) rr_ptr <= act_inc;
            if (cfg_ok) begin
                if (cfg_sel == CFG_SEL_COUNT) count_r[cfg_ch] <= cfg_wdata;
                else                          addr_r[cfg_ch]  <= cfg_wdata;
            end
        end
    end

endmodule

// File: doc/eclair_dma_engine.md
# eclair_dma_engine

Multi-channel DMA engine for the ECLair system bus. Up to NUM_CH peripheral channels present bytes. The engine arbitrates among them round-robin, requests the bus from the CPU with the dma_req/dma_ack handshake, and writes bursts of bytes to consecutive memory addresses with a setup-then-strobe write cycle. Per-channel address and count registers are loaded through a small config port. A sticky done flag per channel drives an interrupt line toward the CPU's int inputs.

## Interface
Parameters:
- NUM_CH, 4, number of channels (1..8)
- ADDR_W, 24, bus address width
- DATA_W, 8, bus data width
- BURST_LEN, 4, maximum beats per bus tenure (≥1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- ch_req  in  NUM_CH  channel i has a byte ready on its ch_data slice
- ch_data  in  NUM_CH*DATA_W  channel i byte at [i*DATA_W +: DATA_W]
- ch_ack  out  NUM_CH  one-cycle pulse: the byte from channel i was written
- dma_req  out  1  bus request to CPU
- dma_ack  in  1  bus grant from CPU; asynchronous, so it is synchronised internally
- bus_addr  out  ADDR_W  write address
- bus_data  out  DATA_W  write data
- bus_write  out  1  write strobe, one cycle high
- cfg_we  in  1  config write enable
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel
- cfg_sel  in  1  0 = address register, 1 = count register
- cfg_wdata  in  ADDR_W  value; count uses the low ADDR_W bits
- ch_done  out  NUM_CH  sticky: channel count reached zero
- irq  out  1  OR of ch_done

## Operation
- Per channel: addr[i] (ADDR_W) and count[i] (ADDR_W). Eligible means ch_req[i]=1 and count[i]≠0.
- Config write: on a cfg_we cycle the selected register loads cfg_wdata. Writing count also clears ch_done[cfg_ch]. A write whose target is the active channel while state≠IDLE is ignored.
- dma_ack passes through a 2-flop synchroniser; ack_s below is the synchronised value.
- FSM states:
  - IDLE: if any channel is eligible, grant the eligible channel with the lowest index at or after rr_ptr (modulo NUM_CH), set dma_req=1, clear the beat counter, and go to REQ.
  - REQ: wait for ack_s=1, then go to LOAD.
  - LOAD: if ch_req[act]=0, go to RELEASE. Otherwise register bus_addr←addr[act] and bus_data←ch_data[act], and go to SETUP.
  - SETUP: bus_write=0 with addr and data stable; go to STROBE.
  - STROBE: bus_write=1 and ch_ack[act]=1. Update addr[act]+1 (wraps modulo 2^ADDR_W), count[act]−1, beats+1. If the new count is 0, set ch_done[act]. Go to RELEASE if the new count is 0, or beats=BURST_LEN, or ack_s=0. Otherwise go to LOAD.
  - RELEASE: dma_req=0, rr_ptr←act+1 (mod NUM_CH); wait for ack_s=0, then go to IDLE.
- If ack_s falls during LOAD or SETUP (grant revoked), go to RELEASE with no write and no ch_ack. In STROBE the beat completes.
- count[i]=0 makes channel i ineligible; its ch_req is ignored.

## Timing
- Reset values: all outputs 0; addr/count/ch_done/rr_ptr 0; state IDLE.
- Reset mid-burst: all outputs drop immediately (asynchronous) and there is no partial ch_ack.
- dma_req rises on the cycle after IDLE sees an eligible channel.
- Grant latency: dma_ack rising edge to first LOAD is 3 cycles (2 synchroniser + REQ).
- Beat: 3 cycles (LOAD, SETUP, STROBE). bus_addr/bus_data stay stable from SETUP through STROBE; bus_write is high only in STROBE.
- A channel sees ch_ack in cycle t and must present its next byte or drop ch_req by t+1, which is when LOAD samples.
- bus_addr/bus_data hold their last values after a write.
- Simultaneous config write to an idle channel and arbitration in the same cycle: arbitration uses the pre-write count.

## Structure
- Package eclair_dma_pkg: FSM state enum (IDLE, REQ, LOAD, SETUP, STROBE, RELEASE) and the cfg_sel encodings.
- Sub-module eclair_rr_arbiter: NUM_CH request vector plus rr_ptr in, one-hot grant and index out. Purely combinational; rr_ptr is held in the engine.
- Synchroniser is inline in the engine.

## Test plan
- Single channel: addr=0x000440, count=1, ch_req[0] with data 0xA5, CPU acks 50 ns later → one write of 0xA5 at 0x000440, ch_done[0]=1, irq=1, dma_req released.
- Burst limit: count=6, BURST_LEN=4, ch_req held high → 4 writes at 0x100–0x103, release, re-request, 2 writes at 0x104–0x105, done.
- Round-robin: ch0 and ch2 both requesting with counts of 8 and BURST_LEN=1 → bursts alternate ch0, ch2, ch0, … and ch_ack goes to the matching channel.
- Edge cases: ch_req drops after the first ch_ack → release with no extra write. Address 0xFFFFFF with count=2 → writes at 0xFFFFFF then 0x000000.
- dma_ack deasserted during SETUP → no bus_write, dma_req falls, count unchanged.
- Config write to the active channel mid-burst is ignored. rst_n pulsed during STROBE → all outputs 0 and state IDLE.
